// File: rtl/qstate_dot_accum_if.sv
// qstate_dot_accum_if
// Bundles the stream-in / result-out signals of the complex dot-product engine.
//   master : the producer/consumer driving amplitudes and accepting results
//   slave  : the engine (qstate_dot_accum)
// Signals:
//   clear            synchronous abort
//   mode             0 = sum |a|^2, 1 = sum conj(a)*b
//   in_valid/in_ready/in_last   input beat handshake
//   a_re,a_im,b_re,b_im         N-bit two's complement amplitudes
//   out_valid/out_ready         result handshake
//   out_re,out_im,out_count,overflow   result payload
interface qstate_dot_accum_if #(
  parameter int N     = 16,
  parameter int CNT_W = 8
);
  logic             clear;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [N-1:0]     a_re;
  logic [N-1:0]     a_im;
  logic [N-1:0]     b_re;
  logic [N-1:0]     b_im;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_re;
  logic [N-1:0]     out_im;
  logic [CNT_W-1:0] out_count;
  logic             overflow;

  modport master (
    output clear, mode, in_valid, in_last, a_re, a_im, b_re, b_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_count, overflow
  );

  modport slave (
    input  clear, mode, in_valid, in_last, a_re, a_im, b_re, b_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_count, overflow
  );
endinterface

// File: rtl/qstate_dot_accum.sv
// qstate_dot_accum
// Streaming fixed-point complex inner-product / norm engine.
//   mode 0 : accumulates |a_k|^2 over a vector (state norm)
//   mode 1 : accumulates conj(a_k)*b_k over a vector (state overlap)
// One beat per cycle; vector ends with in_last. Products are registered
// (stage 1), scaled by >>Q and summed into N+GUARD accumulators (stage 2),
// and the saturated result is presented two cycles after the last beat.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      qstate_dot_accum_if.slave (handshakes, amplitudes, result)
// Configuration macro:
//   QDOT_ROUND_EN  when defined, the >>Q scaling rounds to nearest (ties
//                  toward +inf); otherwise it truncates toward -inf.
module qstate_dot_accum #(
  parameter int N     = 16,
  parameter int Q     = 12,
  parameter int GUARD = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  qstate_dot_accum_if.slave bus
);

  localparam int AW = N + GUARD;   // accumulator width
  localparam int PW = 2 * N;       // full product width
  localparam int SW = PW + 2;      // headroom for lane sum plus accumulator

`ifdef QDOT_ROUND_EN
  localparam logic signed [PW:0] RND = {{PW{1'b0}}, 1'b1} << (Q - 1);
`else
  localparam logic signed [PW:0] RND = '0;
`endif

  // Accumulator range expressed at the wide sum width
  localparam logic signed [SW-1:0] AMAX = {{(SW-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [SW-1:0] AMIN = {{(SW-AW+1){1'b1}}, {(AW-1){1'b0}}};
  // Output range expressed at accumulator width
  localparam logic signed [AW-1:0] OMAX = {{(GUARD+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AW-1:0] OMIN = {{(GUARD+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;
  logic   drain_q;
  logic   ready_c, load_out, release_v, accept;
  logic   mode_q, mode_eff;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ready_c   = 1'b0;
    load_out  = 1'b0;
    release_v = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.in_valid) state_d = bus.in_last ? S_DRAIN : S_ACCUM;
      end
      S_ACCUM: begin
        ready_c = 1'b1;
        if (bus.in_valid && bus.in_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // second DRAIN cycle: last product is now inside the accumulator
        if (drain_q) begin
          state_d  = S_DONE;
          load_out = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d   = S_IDLE;
          release_v = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // abort overrides any beat or result handshake
    if (bus.clear) begin
      state_d   = S_IDLE;
      load_out  = 1'b0;
      release_v = 1'b0;
    end
  end

  assign accept        = bus.in_valid & ready_c & ~bus.clear;
  assign bus.in_ready  = ready_c;
  assign bus.out_valid = (state_q == S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drain_q <= 1'b0;
    else          drain_q <= (state_q == S_DRAIN) && !drain_q && !bus.clear;
  end

  // Mode is taken straight from the port on the first beat, latched after
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          mode_q <= 1'b0;
    else if (accept && state_q == S_IDLE)  mode_q <= bus.mode;
  end
  assign mode_eff = (state_q == S_IDLE) ? bus.mode : mode_q;

  // ---------------------------------------------------------------- stage 1
  logic signed [N-1:0]  a_re_s, a_im_s, b_re_s, b_im_s, x_re_s, x_im_s;
  logic signed [PW-1:0] prod_d [4];
  logic signed [PW-1:0] prod_q [4];
  logic                 p_valid_q;

  assign a_re_s = bus.a_re;
  assign a_im_s = bus.a_im;
  assign b_re_s = bus.b_re;
  assign b_im_s = bus.b_im;
  // In norm mode the "b" operand of the two diagonal products is a itself
  assign x_re_s = mode_eff ? b_re_s : a_re_s;
  assign x_im_s = mode_eff ? b_im_s : a_im_s;

  // [0]=re*re [1]=im*im [2]=a_re*b_im [3]=a_im*b_re (cross terms only in mode 1)
  assign prod_d[0] = PW'(a_re_s) * PW'(x_re_s);
  assign prod_d[1] = PW'(a_im_s) * PW'(x_im_s);
  assign prod_d[2] = mode_eff ? PW'(a_re_s) * PW'(b_im_s) : '0;
  assign prod_d[3] = mode_eff ? PW'(a_im_s) * PW'(b_re_s) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) prod_q[i] <= '0;
    end else if (bus.clear) begin
      p_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) prod_q[i] <= '0;
    end else begin
      p_valid_q <= accept;
      if (accept) begin
        for (int i = 0; i < 4; i++) prod_q[i] <= prod_d[i];
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic signed [PW:0]   shf [4];
  logic signed [SW-1:0] lane_sum [2];
  logic signed [SW-1:0] acc_wide [2];
  logic                 acc_hi [2];
  logic                 acc_lo [2];
  logic signed [AW-1:0] acc_clamp [2];
  logic signed [AW-1:0] acc_q [2];
  logic                 acc_ovf_q;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_shift
      // one extra bit so the rounding offset cannot wrap the product
      assign shf[gi] = ($signed({prod_q[gi][PW-1], prod_q[gi]}) + RND) >>> Q;
    end
  endgenerate

  assign lane_sum[0] = SW'(shf[0]) + SW'(shf[1]);
  assign lane_sum[1] = SW'(shf[2]) - SW'(shf[3]);

  generate
    for (gi = 0; gi < 2; gi++) begin : g_acc
      assign acc_wide[gi]  = SW'(acc_q[gi]) + lane_sum[gi];
      assign acc_hi[gi]    = acc_wide[gi] > AMAX;
      assign acc_lo[gi]    = acc_wide[gi] < AMIN;
      assign acc_clamp[gi] = acc_hi[gi] ? AMAX[AW-1:0] :
                             acc_lo[gi] ? AMIN[AW-1:0] : acc_wide[gi][AW-1:0];
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q;
  logic             cnt_ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q[0]  <= '0;
      acc_q[1]  <= '0;
      acc_ovf_q <= 1'b0;
      cnt_q     <= '0;
      cnt_ovf_q <= 1'b0;
    end else if (bus.clear || release_v) begin
      acc_q[0]  <= '0;
      acc_q[1]  <= '0;
      acc_ovf_q <= 1'b0;
      cnt_q     <= '0;
      cnt_ovf_q <= 1'b0;
    end else begin
      if (p_valid_q) begin
        acc_q[0]  <= acc_clamp[0];
        acc_q[1]  <= acc_clamp[1];
        acc_ovf_q <= acc_ovf_q | acc_hi[0] | acc_lo[0] | acc_hi[1] | acc_lo[1];
      end
      if (accept) begin
        if (cnt_q == '1) cnt_ovf_q <= 1'b1;
        else             cnt_q     <= cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------- output
  logic [N-1:0] sat_val [2];
  logic         sat_any [2];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_sat
      assign sat_any[gi] = (acc_q[gi] > OMAX) || (acc_q[gi] < OMIN);
      assign sat_val[gi] = (acc_q[gi] > OMAX) ? OMAX[N-1:0] :
                           (acc_q[gi] < OMIN) ? OMIN[N-1:0] : acc_q[gi][N-1:0];
    end
  endgenerate

  logic [N-1:0]     out_re_q, out_im_q;
  logic [CNT_W-1:0] out_count_q;
  logic             overflow_q;

  // Result registers keep their value after the handshake until the next load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_count_q <= '0;
      overflow_q  <= 1'b0;
    end else if (load_out) begin
      out_re_q    <= sat_val[0];
      out_im_q    <= sat_val[1];
      out_count_q <= cnt_q;
      overflow_q  <= sat_any[0] | sat_any[1] | acc_ovf_q | cnt_ovf_q;
    end
  end

  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.out_count = out_count_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_qstate_dot_accum.sv
module tb_qstate_dot_accum;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  qstate_dot_accum_if #(.N(16), .CNT_W(8)) bus ();

  qstate_dot_accum #(.N(16), .Q(12), .GUARD(4), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic            m;
    int              n;
    logic [3:0][15:0] ar;
    logic [3:0][15:0] ai;
    logic [3:0][15:0] br;
    logic [3:0][15:0] bi;
    exp_t            e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic vec_t mk(input logic m, input int n, input logic [15:0] re,
                              input logic [15:0] im, input logic [7:0] cnt, input logic ovf);
    vec_t v;
    v.m = m; v.n = n;
    v.ar = '0; v.ai = '0; v.br = '0; v.bi = '0;
    v.e.re = re; v.e.im = im; v.e.cnt = cnt; v.e.ovf = ovf;
    return v;
  endfunction

  // Drives all beats; mode is inverted after the first beat (must be ignored),
  // and an unaccepted in_last bubble follows the first beat of longer vectors.
  task automatic send_vec(input vec_t v);
    int j;
    for (int i = 0; i < v.n; i++) begin
      j = i % 4;
      @(negedge clk);
      bus.mode     = (i == 0) ? v.m : ~v.m;
      bus.in_valid = 1'b1;
      bus.in_last  = (i == v.n - 1);
      bus.a_re = v.ar[j]; bus.a_im = v.ai[j];
      bus.b_re = v.br[j]; bus.b_im = v.bi[j];
      if (i == 0) sb.push_back(v.e);
      @(posedge clk);
      if (i == 0 && v.n > 1) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b1;
        bus.a_re = 16'h7FFF; bus.a_im = 16'h7FFF;
        @(posedge clk);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Called at the first negedge after the last accepted beat
  task automatic collect(input string tag);
    int   lat;
    exp_t e;
    lat = 1;
    chk({tag, " in_ready_drain"}, {31'd0, bus.in_ready}, 32'd0);
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, 32'd3);
    if (sb.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, " out_re"},    {16'd0, bus.out_re},    {16'd0, e.re});
      chk({tag, " out_im"},    {16'd0, bus.out_im},    {16'd0, e.im});
      chk({tag, " out_count"}, {24'd0, bus.out_count}, {24'd0, e.cnt});
      chk({tag, " overflow"},  {31'd0, bus.overflow},  {31'd0, e.ovf});
    end
    $display("%s: re=%h im=%h count=%0d ovf=%b latency=%0d", tag, bus.out_re, bus.out_im,
             bus.out_count, bus.overflow, lat);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [15:0] held;
    send_vec(v);
    collect(tag);
    held = bus.out_re;
    @(negedge clk);
    chk({tag, " out_valid_released"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, " in_ready_idle"},      {31'd0, bus.in_ready},  32'd1);
    chk({tag, " out_re_retained"},    {16'd0, bus.out_re},    {16'd0, held});
  endtask

  task automatic partial_beats(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.mode = 1'b0; bus.in_valid = 1'b1; bus.in_last = 1'b0;
      bus.a_re = 16'h1000; bus.a_im = 16'h0000; bus.b_re = '0; bus.b_im = '0;
      @(posedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(1'b0, 1, 16'h0800, 16'h0000, 8'd1, 1'b0);
    vt[0].ar[0] = 16'h0800; vt[0].ai[0] = 16'h0800;
    vt[1]  = mk(1'b1, 2, 16'h0000, 16'h0000, 8'd2, 1'b0);
    vt[1].ar[0] = 16'h1000; vt[1].bi[0] = 16'h1000;
    vt[1].ai[1] = 16'h1000; vt[1].br[1] = 16'h1000;
    vt[2]  = mk(1'b1, 1, 16'h0000, 16'h1000, 8'd1, 1'b0);
    vt[2].ar[0] = 16'h1000; vt[2].bi[0] = 16'h1000;
    vt[3]  = mk(1'b0, 4, 16'h7FFF, 16'h0000, 8'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      vt[3].ar[i] = 16'h2000; vt[3].ai[i] = 16'h2000;
    end
    vt[4]  = mk(1'b0, 1, 16'h0000, 16'h0000, 8'd1, 1'b0);
    vt[4].ar[0] = 16'h0001;
    vt[5]  = mk(1'b0, 1, 16'h0002, 16'h0000, 8'd1, 1'b0);
    vt[5].ar[0] = 16'h0040; vt[5].ai[0] = 16'h0040;
    vt[6]  = mk(1'b0, 1, 16'h1000, 16'h0000, 8'd1, 1'b0);
    vt[6].ar[0] = 16'hF000;
    vt[7]  = mk(1'b1, 1, 16'h8000, 16'h0000, 8'd1, 1'b1);
    vt[7].ar[0] = 16'h4000; vt[7].br[0] = 16'hC000;
    vt[8]  = mk(1'b1, 1, 16'h2000, 16'h0000, 8'd1, 1'b0);
    vt[8].ar[0] = 16'h1000; vt[8].ai[0] = 16'h1000;
    vt[8].br[0] = 16'h1000; vt[8].bi[0] = 16'h1000;
    vt[9]  = mk(1'b1, 1, 16'h0300, 16'hFD00, 8'd1, 1'b0);
    vt[9].ar[0] = 16'h0800; vt[9].br[0] = 16'h0600; vt[9].bi[0] = 16'hFA00;
    vt[10] = mk(1'b0, 3, 16'h2400, 16'h0000, 8'd3, 1'b0);
    vt[10].ar[0] = 16'h1000; vt[10].ai[1] = 16'h1000; vt[10].ar[2] = 16'h0800;
`ifdef QDOT_ROUND_EN
    vt[11] = mk(1'b1, 1, 16'h0000, 16'h0000, 8'd1, 1'b0);
`else
    vt[11] = mk(1'b1, 1, 16'hFFFF, 16'h0000, 8'd1, 1'b0);
`endif
    vt[11].ar[0] = 16'h0001; vt[11].br[0] = 16'hFFFF;
    vt[12] = mk(1'b0, 255, 16'h0000, 16'h0000, 8'd255, 1'b0);
    vt[13] = mk(1'b0, 256, 16'h0000, 16'h0000, 8'd255, 1'b1);

    reset_n = 1'b0;
    bus.clear = 1'b0; bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset out_re",    {16'd0, bus.out_re},    32'd0);
    chk("reset out_im",    {16'd0, bus.out_im},    32'd0);
    chk("reset out_count", {24'd0, bus.out_count}, 32'd0);
    chk("reset overflow",  {31'd0, bus.overflow},  32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Backpressure: result held, beats ignored while waiting
    bus.out_ready = 1'b0;
    send_vec(vt[0]);
    collect("bp");
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.mode = 1'b0;
      bus.a_re = 16'h2000; bus.a_im = 16'h2000;
      @(negedge clk);
      chk($sformatf("bp%0d out_valid", k), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("bp%0d out_re", k),    {16'd0, bus.out_re},    32'h0800);
      chk($sformatf("bp%0d count", k),     {24'd0, bus.out_count}, 32'd1);
      chk($sformatf("bp%0d in_ready", k),  {31'd0, bus.in_ready},  32'd0);
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp release out_valid", {31'd0, bus.out_valid}, 32'd0);
    run_vec(vt[0], "bp_next");

    // Mid-vector clear, asserted together with a last beat
    partial_beats(3);
    @(negedge clk);
    bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_last = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    chk("clear in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("clear out_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (4) @(negedge clk);
    chk("clear no_result", {31'd0, bus.out_valid}, 32'd0);
    begin
      vec_t v;
      v = mk(1'b0, 1, 16'h1000, 16'h0000, 8'd1, 1'b0);
      v.ar[0] = 16'h1000;
      run_vec(v, "after_clear");
    end

    // Mid-vector asynchronous reset
    partial_beats(3);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("areset out_re",    {16'd0, bus.out_re},    32'd0);
    chk("areset out_im",    {16'd0, bus.out_im},    32'd0);
    chk("areset out_count", {24'd0, bus.out_count}, 32'd0);
    chk("areset overflow",  {31'd0, bus.overflow},  32'd0);
    chk("areset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("areset in_ready",  {31'd0, bus.in_ready},  32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    run_vec(vt[0], "after_reset");

    chk("scoreboard drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
